// File: rtl/alu_cmd_sequencer.sv
// ---------------------------------------------------------------------------
// alu_cmd_sequencer
//
// Command front-end for the 8-bit ALU. It accepts one command per
// valid/ready handshake and keeps a small operand register file. For ALU
// commands it drives registered operands and the control code into the ALU
// for one ISSUE cycle. It then captures the ALU's combinational result and
// flags into the destination register.
//
// LOADI and illegal opcodes complete in the accept cycle and never touch the
// ALU-facing registers.
//
// Ports
//   clk_i, reset_i       clock (rising edge), synchronous active-high reset
//   cmd_valid_i          command present
//   cmd_ready_o          sequencer can accept a command (IDLE, not in reset)
//   cmd_op_i             ALU control code, 4'b1111 = load immediate
//   cmd_srca_i           register index driven onto A
//   cmd_srcb_i           register index driven onto B
//   cmd_imm_en_i         B comes from cmd_imm_i instead of R[srcb]
//   cmd_imm_i            immediate value
//   cmd_dst_i            destination register index
//   alu_ctl_o, a_o, b_o  registered ALU inputs
//   z_i, flags_i         combinational ALU result and flags
//   res_valid_o          one-cycle result strobe
//   res_data_o           value written to the destination
//   res_flags_o          captured flags
//   res_dst_o            destination index
//   clr_err_i            clears sticky_err_o and illegal_o (set wins)
//   sticky_err_o         a captured result had FLAGS[4] or FLAGS[5] set
//   illegal_o            an unsupported opcode was accepted (sticky)
// ---------------------------------------------------------------------------
module alu_cmd_sequencer #(
  parameter int NREGS  = 4,
  parameter int DATA_W = 8
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic [3:0]        cmd_op_i,
  input  logic [1:0]        cmd_srca_i,
  input  logic [1:0]        cmd_srcb_i,
  input  logic              cmd_imm_en_i,
  input  logic [DATA_W-1:0] cmd_imm_i,
  input  logic [1:0]        cmd_dst_i,
  output logic [3:0]        alu_ctl_o,
  output logic [DATA_W-1:0] a_o,
  output logic [DATA_W-1:0] b_o,
  input  logic [DATA_W-1:0] z_i,
  input  logic [7:0]        flags_i,
  output logic              res_valid_o,
  output logic [DATA_W-1:0] res_data_o,
  output logic [7:0]        res_flags_o,
  output logic [1:0]        res_dst_o,
  input  logic              clr_err_i,
  output logic              sticky_err_o,
  output logic              illegal_o
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } state_t;

  state_t state_q, state_d;

  logic [DATA_W-1:0] regFile_q [NREGS];
  logic [DATA_W-1:0] a_q, b_q;
  logic [3:0]        aluCtl_q;
  logic [1:0]        dst_q;
  logic              resValid_q;
  logic [DATA_W-1:0] resData_q;
  logic [7:0]        resFlags_q;
  logic [1:0]        resDst_q;
  logic              stickyErr_q;
  logic              illegal_q;

  logic opIsAlu;
  logic opIsLoadi;
  logic accept;
  logic capture;
  logic errSet;
  logic illegalSet;

  // Opcode decode: only the five codes the ALU implements go through ISSUE.
  always_comb begin
    opIsAlu = 1'b0;
    case (cmd_op_i)
      4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b0110: opIsAlu = 1'b1;
      default:                                     opIsAlu = 1'b0;
    endcase
  end

  assign opIsLoadi  = (cmd_op_i == 4'b1111);
  assign accept     = cmd_valid_i && cmd_ready_o;
  assign capture    = (state_q == ISSUE);
  assign errSet     = capture && (flags_i[4] || flags_i[5]);
  assign illegalSet = accept && !opIsAlu && !opIsLoadi;

  // State register.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: only ALU commands spend a cycle in ISSUE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept && opIsAlu) state_d = ISSUE;
      ISSUE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic: ready is forced low while reset is asserted.
  always_comb begin
    cmd_ready_o = 1'b0;
    if (state_q == IDLE && !reset_i) cmd_ready_o = 1'b1;
  end

  // Datapath. The capture edge writes the register file. A command accepted
  // in the following cycle therefore already sees the new value without any
  // forwarding.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int i = 0; i < NREGS; i++) regFile_q[i] <= '0;
      a_q        <= '0;
      b_q        <= '0;
      aluCtl_q   <= 4'b0000;
      dst_q      <= 2'd0;
      resValid_q <= 1'b0;
      resData_q  <= '0;
      resFlags_q <= 8'h00;
      resDst_q   <= 2'd0;
    end else begin
      resValid_q <= 1'b0;
      if (capture) begin
        regFile_q[dst_q] <= z_i;
        resValid_q       <= 1'b1;
        resData_q        <= z_i;
        resFlags_q       <= flags_i;
        resDst_q         <= dst_q;
      end else if (accept) begin
        if (opIsAlu) begin
          a_q      <= regFile_q[cmd_srca_i];
          b_q      <= cmd_imm_en_i ? cmd_imm_i : regFile_q[cmd_srcb_i];
          aluCtl_q <= cmd_op_i;
          dst_q    <= cmd_dst_i;
        end else begin
          if (opIsLoadi) regFile_q[cmd_dst_i] <= cmd_imm_i;
          resValid_q <= 1'b1;
          resData_q  <= opIsLoadi ? cmd_imm_i : '0;
          resFlags_q <= 8'h00;
          resDst_q   <= cmd_dst_i;
        end
      end
    end
  end

  // Sticky status bits. A set in the same cycle as a clear takes priority.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      stickyErr_q <= 1'b0;
      illegal_q   <= 1'b0;
    end else begin
      stickyErr_q <= errSet || (stickyErr_q && !clr_err_i);
      illegal_q   <= illegalSet || (illegal_q && !clr_err_i);
    end
  end

  assign alu_ctl_o    = aluCtl_q;
  assign a_o          = a_q;
  assign b_o          = b_q;
  assign res_valid_o  = resValid_q;
  assign res_data_o   = resData_q;
  assign res_flags_o  = resFlags_q;
  assign res_dst_o    = resDst_q;
  assign sticky_err_o = stickyErr_q;
  assign illegal_o    = illegal_q;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// ---------------------------------------------------------------------------
// tb_alu_cmd_sequencer
//
// Drives directed and random commands into alu_cmd_sequencer. A stub ALU
// computes Z from the registered A/B/ALU_CTL, and FLAGS come from a bench
// variable. A command-level reference model tracks the register file,
// latched operands, result fields and sticky bits.
// ---------------------------------------------------------------------------
module tb_alu_cmd_sequencer;

  logic       clk_i = 1'b0;
  logic       reset_i;
  logic       cmd_valid_i;
  logic       cmd_ready_o;
  logic [3:0] cmd_op_i;
  logic [1:0] cmd_srca_i;
  logic [1:0] cmd_srcb_i;
  logic       cmd_imm_en_i;
  logic [7:0] cmd_imm_i;
  logic [1:0] cmd_dst_i;
  logic [3:0] alu_ctl_o;
  logic [7:0] a_o;
  logic [7:0] b_o;
  logic [7:0] z_i;
  logic [7:0] flags_i;
  logic       res_valid_o;
  logic [7:0] res_data_o;
  logic [7:0] res_flags_o;
  logic [1:0] res_dst_o;
  logic       clr_err_i;
  logic       sticky_err_o;
  logic       illegal_o;

  int total = 0;
  int bad   = 0;

  logic [7:0] stubFlags;

  logic [7:0] modelRegs [4];
  logic [7:0] modelA, modelB, modelResData;
  logic [3:0] modelCtl;
  logic       modelSticky, modelIllegal;

  alu_cmd_sequencer #(.NREGS(4), .DATA_W(8)) dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
    .cmd_op_i(cmd_op_i), .cmd_srca_i(cmd_srca_i), .cmd_srcb_i(cmd_srcb_i),
    .cmd_imm_en_i(cmd_imm_en_i), .cmd_imm_i(cmd_imm_i), .cmd_dst_i(cmd_dst_i),
    .alu_ctl_o(alu_ctl_o), .a_o(a_o), .b_o(b_o),
    .z_i(z_i), .flags_i(flags_i),
    .res_valid_o(res_valid_o), .res_data_o(res_data_o),
    .res_flags_o(res_flags_o), .res_dst_o(res_dst_o),
    .clr_err_i(clr_err_i), .sticky_err_o(sticky_err_o), .illegal_o(illegal_o)
  );

  always #5 clk_i = ~clk_i;

  // Stand-in ALU behaviour. Only its arithmetic matters to the bench.
  function automatic logic [7:0] aluRef(input logic [3:0] op, input logic [7:0] a,
                                        input logic [7:0] b);
    int r;
    case (op)
      4'b0000: r = int'(a) + int'(b);
      4'b0001: r = int'(a) - int'(b);
      4'b0010: r = int'(a & b);
      4'b0100: r = int'(a) * int'(b);
      4'b0110: r = int'(a ^ b);
      default: r = 0;
    endcase
    return r[7:0];
  endfunction

  function automatic bit isAluOp(input logic [3:0] op);
    return op inside {4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b0110};
  endfunction

  // The stub ALU is combinational from the sequencer's registered outputs.
  always_comb z_i = aluRef(alu_ctl_o, a_o, b_o);
  assign flags_i = stubFlags;

  // Single comparison point for every check in the bench.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic modelReset();
    for (int i = 0; i < 4; i++) modelRegs[i] = 8'h00;
    modelA       = 8'h00;
    modelB       = 8'h00;
    modelCtl     = 4'h0;
    modelResData = 8'h00;
    modelSticky  = 1'b0;
    modelIllegal = 1'b0;
  endtask

  // Issues one command, starting just after a rising edge while the DUT is idle.
  // It returns just after the edge that produced the result, so the next
  // call is accepted in the result cycle.
  task automatic applyStimulus(input logic [3:0] op, input logic [1:0] srca,
                               input logic [1:0] srcb, input logic immEn,
                               input logic [7:0] imm, input logic [1:0] dst,
                               input logic [7:0] flags, input logic clr);
    logic [7:0] expZ;
    cmd_valid_i  = 1'b1;
    cmd_op_i     = op;
    cmd_srca_i   = srca;
    cmd_srcb_i   = srcb;
    cmd_imm_en_i = immEn;
    cmd_imm_i    = imm;
    cmd_dst_i    = dst;
    stubFlags    = flags;
    clr_err_i    = isAluOp(op) ? 1'b0 : clr;
    @(negedge clk_i);
    checkOutput("readyBeforeAccept", cmd_ready_o, 1);
    @(posedge clk_i);
    #1;
    cmd_valid_i = 1'b0;
    clr_err_i   = 1'b0;
    if (isAluOp(op)) begin
      modelA   = modelRegs[srca];
      modelB   = immEn ? imm : modelRegs[srcb];
      modelCtl = op;
      checkOutput("issueA", a_o, modelA);
      checkOutput("issueB", b_o, modelB);
      checkOutput("issueCtl", alu_ctl_o, modelCtl);
      checkOutput("issueReady", cmd_ready_o, 0);
      checkOutput("issueNoRes", res_valid_o, 0);
      clr_err_i = clr;
      @(posedge clk_i);
      #1;
      clr_err_i      = 1'b0;
      expZ           = aluRef(op, modelA, modelB);
      modelRegs[dst] = expZ;
      modelResData   = expZ;
      modelSticky    = (flags[4] | flags[5]) | (modelSticky & ~clr);
      modelIllegal   = modelIllegal & ~clr;
      checkOutput("aluResValid", res_valid_o, 1);
      checkOutput("aluResData", res_data_o, expZ);
      checkOutput("aluResFlags", res_flags_o, flags);
      checkOutput("aluResDst", res_dst_o, dst);
    end else if (op == 4'b1111) begin
      modelRegs[dst] = imm;
      modelResData   = imm;
      modelSticky    = modelSticky & ~clr;
      modelIllegal   = modelIllegal & ~clr;
      checkOutput("ldiResValid", res_valid_o, 1);
      checkOutput("ldiResData", res_data_o, imm);
      checkOutput("ldiResFlags", res_flags_o, 0);
      checkOutput("ldiResDst", res_dst_o, dst);
      checkOutput("ldiHoldA", a_o, modelA);
      checkOutput("ldiHoldB", b_o, modelB);
    end else begin
      modelResData = 8'h00;
      modelSticky  = modelSticky & ~clr;
      modelIllegal = 1'b1;
      checkOutput("illResValid", res_valid_o, 1);
      checkOutput("illResData", res_data_o, 0);
      checkOutput("illResFlags", res_flags_o, 0);
      checkOutput("illHoldCtl", alu_ctl_o, modelCtl);
    end
    checkOutput("readyAfter", cmd_ready_o, 1);
    checkOutput("stickyErr", sticky_err_o, modelSticky);
    checkOutput("illegal", illegal_o, modelIllegal);
  endtask

  // Rewrites R[idx] with itself (ADD imm 0) so that the issue checks expose it.
  task automatic readReg(input logic [1:0] idx);
    applyStimulus(4'b0000, idx, 2'd0, 1'b1, 8'h00, idx, 8'h00, 1'b0);
  endtask

  task automatic idleCycle();
    @(posedge clk_i);
    #1;
    checkOutput("idleNoRes", res_valid_o, 0);
    checkOutput("idleHoldData", res_data_o, modelResData);
  endtask

  task automatic pulseClear();
    clr_err_i = 1'b1;
    @(posedge clk_i);
    #1;
    clr_err_i    = 1'b0;
    modelSticky  = 1'b0;
    modelIllegal = 1'b0;
    checkOutput("clrSticky", sticky_err_o, 0);
    checkOutput("clrIllegal", illegal_o, 0);
  endtask

  initial begin
    logic [3:0] opTable [7];
    logic [3:0] op;
    logic [7:0] flags;
    opTable[0] = 4'b0000; opTable[1] = 4'b0001; opTable[2] = 4'b0010;
    opTable[3] = 4'b0100; opTable[4] = 4'b0110; opTable[5] = 4'b1111;
    opTable[6] = 4'b0011;

    reset_i = 1'b1; cmd_valid_i = 1'b0; cmd_op_i = 4'h0; cmd_srca_i = 2'd0;
    cmd_srcb_i = 2'd0; cmd_imm_en_i = 1'b0; cmd_imm_i = 8'h00; cmd_dst_i = 2'd0;
    clr_err_i = 1'b0; stubFlags = 8'h00;
    modelReset();
    repeat (3) @(posedge clk_i);
    #1;
    checkOutput("readyInReset", cmd_ready_o, 0);
    reset_i = 1'b0;
    #1;
    checkOutput("rstReady", cmd_ready_o, 1);
    checkOutput("rstA", a_o, 0);
    checkOutput("rstB", b_o, 0);
    checkOutput("rstCtl", alu_ctl_o, 0);
    checkOutput("rstResValid", res_valid_o, 0);
    checkOutput("rstResData", res_data_o, 0);
    checkOutput("rstResFlags", res_flags_o, 0);
    checkOutput("rstResDst", res_dst_o, 0);
    checkOutput("rstSticky", sticky_err_o, 0);
    checkOutput("rstIllegal", illegal_o, 0);

    $display("[TB] directed sequence");
    applyStimulus(4'b1111, 2'd0, 2'd0, 1'b0, 8'h05, 2'd0, 8'h00, 1'b0);
    applyStimulus(4'b1111, 2'd0, 2'd0, 1'b0, 8'h03, 2'd1, 8'h00, 1'b0);
    applyStimulus(4'b0000, 2'd0, 2'd1, 1'b0, 8'h00, 2'd2, 8'h00, 1'b0);
    idleCycle();
    applyStimulus(4'b0000, 2'd0, 2'd1, 1'b0, 8'h00, 2'd2, 8'h00, 1'b0);
    applyStimulus(4'b0001, 2'd2, 2'd0, 1'b1, 8'h08, 2'd3, 8'h00, 1'b0);
    checkOutput("subZero", res_data_o, 8'h00);

    applyStimulus(4'b0100, 2'd0, 2'd1, 1'b0, 8'h00, 2'd3, 8'h10, 1'b0);
    checkOutput("multSetsErr", sticky_err_o, 1);
    applyStimulus(4'b0100, 2'd0, 2'd1, 1'b0, 8'h00, 2'd3, 8'h20, 1'b1);
    checkOutput("setWinsErr", sticky_err_o, 1);
    idleCycle();
    pulseClear();

    applyStimulus(4'b1010, 2'd0, 2'd0, 1'b0, 8'h77, 2'd1, 8'h00, 1'b0);
    checkOutput("illegalSet", illegal_o, 1);
    for (int i = 0; i < 4; i++) readReg(2'(i));
    idleCycle();

    // Reset arriving during ISSUE aborts the pending write to R2.
    cmd_valid_i = 1'b1; cmd_op_i = 4'b0000; cmd_srca_i = 2'd0; cmd_srcb_i = 2'd1;
    cmd_imm_en_i = 1'b0; cmd_dst_i = 2'd2; stubFlags = 8'h00;
    @(negedge clk_i);
    checkOutput("abortAcceptReady", cmd_ready_o, 1);
    @(posedge clk_i);
    #1;
    cmd_valid_i = 1'b0;
    checkOutput("abortIssueA", a_o, modelRegs[0]);
    reset_i = 1'b1;
    @(negedge clk_i);
    checkOutput("abortReadyLow", cmd_ready_o, 0);
    @(posedge clk_i);
    #1;
    reset_i = 1'b0;
    modelReset();
    #1;
    checkOutput("abortNoRes", res_valid_o, 0);
    checkOutput("abortA", a_o, 0);
    checkOutput("abortB", b_o, 0);
    checkOutput("abortReady", cmd_ready_o, 1);
    readReg(2'd2);

    $display("[TB] random sequence");
    for (int n = 0; n < 80; n++) begin
      op = opTable[$urandom_range(0, 6)];
      if (op == 4'b0011) op = 4'($urandom_range(7, 14));
      flags = 8'($urandom());
      if ($urandom_range(0, 3) != 0) flags = flags & 8'hCF;
      applyStimulus(op, 2'($urandom()), 2'($urandom()), 1'($urandom()),
                    8'($urandom()), 2'($urandom()), flags, ($urandom_range(0, 3) == 0));
      if ($urandom_range(0, 3) == 0) idleCycle();
    end
    for (int i = 0; i < 4; i++) readReg(2'(i));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
